// File: rtl/alu_wb_buffer.sv
// Writeback skid buffer between the ALU and the scoreboard: a small circular FIFO
// that decouples ALU results from writeback backpressure and counts stall cycles.
module alu_wb_buffer #(
   parameter int XLEN          = 64,
   parameter int TRANS_ID_BITS = 3,
   parameter int DEPTH         = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
   input  logic [XLEN-1:0]            result_i,
   input  logic                       is_branch_i,
   input  logic                       branch_res_i,
   output logic                       wb_valid_o,
   input  logic                       wb_ready_i,
   output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
   output logic [XLEN-1:0]            wb_result_o,
   output logic                       wb_is_branch_o,
   output logic                       wb_branch_res_o,
   output logic [$clog2(DEPTH):0]     occupancy_o,
   output logic [15:0]                stall_cnt_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [TRANS_ID_BITS-1:0] r_memId     [DEPTH];
   logic [XLEN-1:0]          r_memResult [DEPTH];
   logic                     r_memBranch [DEPTH];
   logic                     r_memBrRes  [DEPTH];

   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_stallCnt;

   logic w_ready;
   logic w_wbValid;
   logic w_push;
   logic w_pop;

   assign w_ready   = (r_count < FULL_CNT);
   assign w_wbValid = (r_count != '0);
   assign w_push    = valid_i && w_ready && !flush_i;
   assign w_pop     = w_wbValid && wb_ready_i && !flush_i;

   assign ready_o         = w_ready;
   assign wb_valid_o      = w_wbValid;
   assign wb_trans_id_o   = r_memId[r_rdPtr];
   assign wb_result_o     = r_memResult[r_rdPtr];
   assign wb_is_branch_o  = r_memBranch[r_rdPtr];
   assign wb_branch_res_o = r_memBrRes[r_rdPtr];
   assign occupancy_o     = r_count;
   assign stall_cnt_o     = r_stallCnt;

   // Entry storage; pointers are power-of-two wide so they wrap on their own.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_memId[i]     <= '0;
            r_memResult[i] <= '0;
            r_memBranch[i] <= 1'b0;
            r_memBrRes[i]  <= 1'b0;
         end
      end else if (w_push) begin
         r_memId[r_wrPtr]     <= trans_id_i;
         r_memResult[r_wrPtr] <= result_i;
         r_memBranch[r_wrPtr] <= is_branch_i;
         r_memBrRes[r_wrPtr]  <= is_branch_i & branch_res_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // A request arriving with flush is dropped rather than held off, so it is not a stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stallCnt <= '0;
      end else if (valid_i && !w_ready && !flush_i && (r_stallCnt != 16'hFFFF)) begin
         r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

endmodule
